mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder -- single-port memory request responder.
//
// Accepts one-cycle read/write strobes from a CPU-style master and either
// forwards them to an external synchronous RAM or serves them from a small
// I/O block. Completion is signalled with a one-cycle memReady pulse.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   memRead     read strobe (one cycle)
//   memWrite    write strobe (one cycle); wins if memRead is also high
//   memAdr      request address
//   memDataIn   write data
//   memDataOut  registered read data, updated only on read completion
//   memReady    one-cycle completion pulse (high only in RESP)
//   reqDropped  sticky flag: a strobe arrived while busy (cleared by reset)
//   ramAdr      registered RAM word address
//   ramWe       registered RAM write enable (high only in WR)
//   ramDin      registered RAM write data
//   ramDout     RAM read data, valid one edge after ramAdr is sampled
//   switches    asynchronous board inputs (2-flop synchronized)
//   leds        LED register
//
// I/O map (addresses >= IO_BASE):
//   IO_BASE+0  switches (read only; writes acknowledged and ignored)
//   IO_BASE+1  leds (read/write)
//   IO_BASE+2  free-running cycle counter, present only when the macro
//              MEM_RESP_TIMER_EN is defined; otherwise reads 0
//   others     read 0, writes acknowledged and ignored

module mem_responder #(
  parameter int               WIDTH     = 16,
  parameter int               ADDR_BITS = 12,
  parameter logic [WIDTH-1:0] IO_BASE   = 16'hFF00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic [WIDTH-1:0]     memAdr,
  input  logic [WIDTH-1:0]     memDataIn,
  output logic [WIDTH-1:0]     memDataOut,
  output logic                 memReady,
  output logic                 reqDropped,
  output logic [ADDR_BITS-1:0] ramAdr,
  output logic                 ramWe,
  output logic [WIDTH-1:0]     ramDin,
  input  logic [WIDTH-1:0]     ramDout,
  input  logic [WIDTH-1:0]     switches,
  output logic [WIDTH-1:0]     leds
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] OFF_SW  = WIDTH'(2'd0);
  localparam logic [WIDTH-1:0] OFF_LED = WIDTH'(2'd1);
  localparam logic [WIDTH-1:0] OFF_CNT = WIDTH'(2'd2);

  state_t           state_r;
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic             strobe_s;
  logic             is_io_s;
  logic [WIDTH-1:0] io_off_s;
  logic [WIDTH-1:0] io_rdata_s;
  logic [WIDTH-1:0] cnt_rd_s;

`ifdef MEM_RESP_TIMER_EN
  logic [WIDTH-1:0] cnt_r;
  logic             cnt_load_s;

  // Counter load happens only for an accepted I/O write to the counter slot
  always_comb begin
    if ((state_r == IDLE) && memWrite && is_io_s && (io_off_s == OFF_CNT)) begin
      cnt_load_s = 1'b1;
    end else begin
      cnt_load_s = 1'b0;
    end
  end

  // Free-running cycle counter; a load takes priority over the increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (cnt_load_s) begin
      cnt_r <= memDataIn;
    end else begin
      cnt_r <= cnt_r + WIDTH'(1'b1);
    end
  end

  assign cnt_rd_s = cnt_r;
`else
  assign cnt_rd_s = '0;
`endif

  // Request decode and I/O read multiplexer
  always_comb begin
    strobe_s = memRead | memWrite;
    is_io_s  = (memAdr >= IO_BASE);
    // Offset is only meaningful when is_io_s; wraps harmlessly otherwise
    io_off_s = memAdr - IO_BASE;
    case (io_off_s)
      OFF_SW:  io_rdata_s = sync2_r;
      OFF_LED: io_rdata_s = leds;
      OFF_CNT: io_rdata_s = cnt_rd_s;
      default: io_rdata_s = '0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= switches;
      sync2_r <= sync1_r;
    end
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      memDataOut <= '0;
      memReady   <= 1'b0;
      reqDropped <= 1'b0;
      ramAdr     <= '0;
      ramWe      <= 1'b0;
      ramDin     <= '0;
      leds       <= '0;
    end else begin
      // memReady and ramWe are pulses tied to entering RESP / WR
      memReady <= 1'b0;
      ramWe    <= 1'b0;
      if ((state_r != IDLE) && strobe_s) begin
        reqDropped <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (memWrite) begin
            if (is_io_s) begin
              if (io_off_s == OFF_LED) begin
                leds <= memDataIn;
              end
              memReady <= 1'b1;
              state_r  <= RESP;
            end else begin
              ramAdr  <= memAdr[ADDR_BITS-1:0];
              ramDin  <= memDataIn;
              ramWe   <= 1'b1;
              state_r <= WR;
            end
          end else if (memRead) begin
            if (is_io_s) begin
              memDataOut <= io_rdata_s;
              memReady   <= 1'b1;
              state_r    <= RESP;
            end else begin
              ramAdr  <= memAdr[ADDR_BITS-1:0];
              state_r <= RD_WAIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        // RAM samples ramAdr on this edge; data is ready on the next one
        RD_WAIT: state_r <= RD_CAP;
        RD_CAP: begin
          memDataOut <= ramDout;
          memReady   <= 1'b1;
          state_r    <= RESP;
        end
        WR: begin
          memReady <= 1'b1;
          state_r  <= RESP;
        end
        RESP:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
